// File: rtl/common_pkg.sv
// Shared defaults for the NoC building blocks: payload width, VC count and
// downstream VC FIFO depth.
package common_pkg;

  localparam int DEFAULT_D_W           = 8;
  localparam int DEFAULT_VC_W          = 2;
  localparam int DEFAULT_VC_FIFO_DEPTH = 4;

endpackage

// File: rtl/noc_vc_rr_pick.sv
// Round-robin one-hot picker: grants the first eligible VC strictly after
// last_gnt, wrapping around; an all-zero last_gnt starts the search at VC0.
module noc_vc_rr_pick #(
  parameter int VC_W = 2
) (
  input  logic [VC_W-1:0] eligible,
  input  logic [VC_W-1:0] last_gnt,
  output logic [VC_W-1:0] gnt
);

  logic [VC_W-1:0] above_mask;
  logic [VC_W-1:0] eligible_hi;

  // Bits strictly above the one-hot last grant; the top VC yields an empty mask.
  assign above_mask  = ~((last_gnt << 1) - VC_W'(1));
  assign eligible_hi = eligible & above_mask;

  assign gnt = (eligible_hi != '0) ? (eligible_hi & (~eligible_hi + VC_W'(1)))
                                   : (eligible & (~eligible + VC_W'(1)));

endmodule

// File: rtl/noc_inject_ni.sv
// Injection network interface: buffers client packets in a 2-entry FIFO and
// issues them to a switch rx port under per-VC credit flow control.
module noc_inject_ni
  import common_pkg::*;
#(
  parameter int N             = 2,
  parameter int A_W           = $clog2(N) + 1,
  parameter int D_W           = DEFAULT_D_W,
  parameter int VC_W          = DEFAULT_VC_W,
  parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       in_dest,
  input  logic [D_W-1:0]       in_data,
  output logic [VC_W-1:0]      tx_vc_target,
  output logic [A_W+D_W-1:0]   tx_packet,
  input  logic [VC_W-1:0]      tx_vc_credit_gnt,
  output logic                 err_credit_ovf,
  output logic [31:0]          sent_count
);

  localparam int                CRED_W   = $clog2(VC_FIFO_DEPTH) + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_FIFO_DEPTH - 1);
  localparam int                PKT_W    = A_W + D_W;

  logic [PKT_W-1:0]  fifo_q [2];
  logic [PKT_W-1:0]  fifo_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic [CRED_W-1:0] credit_q [VC_W];
  logic [CRED_W-1:0] credit_d [VC_W];
  logic [VC_W-1:0]   last_q, last_d;
  logic [VC_W-1:0]   tx_vc_target_q, tx_vc_target_d;
  logic [PKT_W-1:0]  tx_packet_q, tx_packet_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       sent_q, sent_d;

  logic [VC_W-1:0]   eligible;
  logic [VC_W-1:0]   pick;
  logic [VC_W-1:0]   issue_vc;
  logic [VC_W-1:0]   ovf_hit;
  logic              push;
  logic              pop;

  noc_vc_rr_pick #(
    .VC_W (VC_W)
  ) u_pick (
    .eligible (eligible),
    .last_gnt (last_q),
    .gnt      (pick)
  );

  assign issue_vc = (count_q != 2'd0) ? pick : '0;
  assign pop      = |issue_vc;
  assign push     = in_valid & in_ready_q;

  // A grant and an issue on the same VC cancel; a grant at full credit saturates.
  generate
    for (genvar gi = 0; gi < VC_W; gi++) begin : g_credit
      logic inc;
      logic dec;
      assign eligible[gi] = (credit_q[gi] != '0);
      assign inc          = tx_vc_credit_gnt[gi] & ~issue_vc[gi] & (credit_q[gi] != CRED_MAX);
      assign dec          = issue_vc[gi] & ~tx_vc_credit_gnt[gi];
      assign ovf_hit[gi]  = tx_vc_credit_gnt[gi] & ~issue_vc[gi] & (credit_q[gi] == CRED_MAX);
      assign credit_d[gi] = inc ? credit_q[gi] + CRED_W'(1) :
                            dec ? credit_q[gi] - CRED_W'(1) : credit_q[gi];
    end
  endgenerate

  always_comb begin
    fifo_d         = fifo_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    tx_packet_d    = tx_packet_q;
    last_d         = last_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {in_dest, in_data};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d    = ~rd_ptr_q;
      tx_packet_d = fifo_q[rd_ptr_q];
      last_d      = issue_vc;
    end
    count_d        = count_q + {1'b0, push} - {1'b0, pop};
    in_ready_d     = ~count_d[1];
    tx_vc_target_d = issue_vc;
    sent_d         = sent_q + 32'(pop);
    ovf_d          = ovf_q | (|ovf_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      in_ready_q     <= 1'b0;
      for (int i = 0; i < VC_W; i++) begin
        credit_q[i] <= CRED_MAX;
      end
      last_q         <= VC_W'(1) << (VC_W - 1);
      tx_vc_target_q <= '0;
      tx_packet_q    <= '0;
      ovf_q          <= 1'b0;
      sent_q         <= 32'd0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      in_ready_q     <= in_ready_d;
      for (int i = 0; i < VC_W; i++) begin
        credit_q[i] <= credit_d[i];
      end
      last_q         <= last_d;
      tx_vc_target_q <= tx_vc_target_d;
      tx_packet_q    <= tx_packet_d;
      ovf_q          <= ovf_d;
      sent_q         <= sent_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign in_ready       = in_ready_q;
  assign tx_vc_target   = tx_vc_target_q;
  assign tx_packet      = tx_packet_q;
  assign err_credit_ovf = ovf_q;
  assign sent_count     = sent_q;

endmodule

// File: tb/tb_noc_inject_ni.sv
// Directed plus randomized bench for noc_inject_ni against a queue-based
// reference model of the credit/round-robin injection rules.
module tb_noc_inject_ni;

  localparam int N     = 2;
  localparam int A_W   = 2;
  localparam int D_W   = 8;
  localparam int VC_W  = 2;
  localparam int DEPTH = 4;
  localparam int CMAX  = DEPTH - 1;
  localparam int PKT_W = A_W + D_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [A_W-1:0]     in_dest;
  logic [D_W-1:0]     in_data;
  logic [VC_W-1:0]    tx_vc_target;
  logic [PKT_W-1:0]   tx_packet;
  logic [VC_W-1:0]    tx_vc_credit_gnt;
  logic               err_credit_ovf;
  logic [31:0]        sent_count;

  always #5 clk = ~clk;

  noc_inject_ni #(
    .N             (N),
    .A_W           (A_W),
    .D_W           (D_W),
    .VC_W          (VC_W),
    .VC_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_dest          (in_dest),
    .in_data          (in_data),
    .tx_vc_target     (tx_vc_target),
    .tx_packet        (tx_packet),
    .tx_vc_credit_gnt (tx_vc_credit_gnt),
    .err_credit_ovf   (err_credit_ovf),
    .sent_count       (sent_count)
  );

  // Reference model state
  logic [PKT_W-1:0] mq[$];
  int               cred[VC_W];
  int               last_vc;
  logic [VC_W-1:0]  m_target;
  logic [PKT_W-1:0] m_pkt;
  logic             m_ovf;
  logic [31:0]      m_sent;
  logic             m_ready;
  int               accepted;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int v = 0; v < VC_W; v++) cred[v] = CMAX;
    last_vc  = VC_W - 1;
    m_target = '0;
    m_pkt    = '0;
    m_ovf    = 1'b0;
    m_sent   = 32'd0;
    m_ready  = 1'b0;
  endtask

  task automatic check_credits(input string tag);
    for (int v = 0; v < VC_W; v++) begin
      check($sformatf("%s_credit%0d", tag, v), 64'(dut.credit_q[v]), 64'(cred[v]));
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic cycle(input logic r, input logic v, input logic [A_W-1:0] d,
                       input logic [D_W-1:0] dat, input logic [VC_W-1:0] g);
    logic accept;
    int   pick;
    int   cand;
    rst              = r;
    in_valid         = v;
    in_dest          = d;
    in_data          = dat;
    tx_vc_credit_gnt = g;
    accept           = r && v && m_ready;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      pick = -1;
      if (mq.size() > 0) begin
        for (int k = 1; k <= VC_W; k++) begin
          cand = (last_vc + k) % VC_W;
          if (pick < 0 && cred[cand] > 0) pick = cand;
        end
      end
      m_target = '0;
      if (pick >= 0) begin
        m_target = VC_W'(1) << pick;
        m_pkt    = mq.pop_front();
        cred[pick]--;
        last_vc  = pick;
        m_sent   = m_sent + 32'd1;
      end
      for (int vv = 0; vv < VC_W; vv++) begin
        if (((g >> vv) & VC_W'(1)) != '0) begin
          if (cred[vv] == CMAX) m_ovf = 1'b1;
          else cred[vv]++;
        end
      end
      if (accept) begin
        mq.push_back({d, dat});
        accepted++;
      end
      m_ready = (mq.size() < 2);
    end
    #1;
    if (m_target != '0)
      $display("tx vc=%b pkt=%h sent=%0d", tx_vc_target, tx_packet, sent_count);
    check("in_ready",     64'(in_ready),       64'(m_ready));
    check("tx_vc_target", 64'(tx_vc_target),   64'(m_target));
    check("tx_packet",    64'(tx_packet),      64'(m_pkt));
    check("err_ovf",      64'(err_credit_ovf), 64'(m_ovf));
    check("sent_count",   64'(sent_count),     64'(m_sent));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, '0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Offer packets every cycle until n have been accepted, bounded.
  task automatic push_n(input int n, input string tag);
    int start;
    int budget;
    start  = accepted;
    budget = 0;
    while (accepted - start < n && budget < 60) begin
      cycle(1'b1, 1'b1, A_W'($urandom_range(0, 3)), D_W'($urandom), '0);
      budget++;
    end
    check({tag, "_accepted"}, 64'(accepted - start), 64'(n));
  endtask

  logic [PKT_W-1:0] expect_pkt;

  initial begin
    accepted         = 0;
    model_reset();
    rst              = 1'b0;
    in_valid         = 1'b0;
    in_dest          = '0;
    in_data          = '0;
    tx_vc_credit_gnt = '0;

    // Reset state
    do_reset();
    check("rst_ready",  64'(in_ready),     64'd0);
    check("rst_target", 64'(tx_vc_target), 64'd0);
    check("rst_packet", 64'(tx_packet),    64'd0);
    check_credits("rst");
    idle(1);
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // Single packet, one-cycle latency on VC0
    cycle(1'b1, 1'b1, 2'd1, 8'hA5, '0);
    idle(1);
    check("single_target", 64'(tx_vc_target), 64'b01);
    check("single_packet", 64'(tx_packet),     64'h1A5);
    check("single_sent",   64'(sent_count),    64'd1);

    // Eight back-to-back with no grants: six issued, then stall with 2 held
    do_reset();
    idle(1);
    push_n(8, "burst");
    idle(4);
    check("stall_sent",  64'(sent_count), 64'd6);
    check("stall_ready", 64'(in_ready),   64'd0);
    check("stall_held",  64'(mq.size()),  64'd2);
    check_credits("stall");

    // One VC1 grant releases exactly one packet on VC1, in order
    expect_pkt = mq[0];
    cycle(1'b1, 1'b0, '0, '0, 2'b10);
    check("gnt_no_issue_yet", 64'(tx_vc_target), 64'd0);
    idle(1);
    check("gnt_target", 64'(tx_vc_target), 64'b10);
    check("gnt_packet", 64'(tx_packet),    64'(expect_pkt));
    idle(3);
    check("gnt_sent", 64'(sent_count), 64'd7);

    // Refill to 2 buffered, then reset mid-operation
    push_n(1, "refill");
    idle(1);
    check("refill_ready", 64'(in_ready), 64'd0);
    do_reset();
    check("midrst_target", 64'(tx_vc_target), 64'd0);
    idle(1);
    check("midrst_ready", 64'(in_ready), 64'd1);
    check_credits("midrst");

    // Grant at full credit sets the sticky overflow flag
    cycle(1'b1, 1'b0, '0, '0, 2'b01);
    idle(3);
    check("ovf_sticky", 64'(err_credit_ovf), 64'd1);
    check_credits("ovf");

    // Grant and issue on the same VC at credit 1 nets to no change
    do_reset();
    idle(1);
    push_n(6, "drain");
    idle(2);
    cycle(1'b1, 1'b0, '0, '0, 2'b01);
    push_n(1, "same");
    cycle(1'b1, 1'b0, '0, '0, 2'b01);
    check("same_target", 64'(tx_vc_target), 64'b01);
    check("same_credit0", 64'(dut.credit_q[0]), 64'd1);

    // Randomized traffic with sporadic grants and resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) != 0),
            1'($urandom_range(0, 1)),
            A_W'($urandom),
            D_W'($urandom),
            ($urandom_range(0, 2) == 0) ? VC_W'($urandom) : '0);
      if (i % 50 == 49) check_credits("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_inject_ni.md
NOC_INJECT_NI -- requirements
Module: noc_inject_ni

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N, 2, number of clients.
- A_W, $clog2(N)+1, address width.
- D_W, DEFAULT_D_W, payload width.
- VC_W, DEFAULT_VC_W, number of virtual channels, one bit each.
- VC_FIFO_DEPTH, DEFAULT_VC_FIFO_DEPTH, downstream VC FIFO depth; usable credits are VC_FIFO_DEPTH-1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-low reset.
- in_valid, in, 1, client offers a packet.
- in_ready, out, 1, block can accept a packet.
- in_dest, in, A_W, destination address.
- in_data, in, D_W, payload.
- tx_vc_target, out, VC_W, one-hot VC select; nonzero means a packet is presented this cycle.
- tx_packet, out, A_W+D_W, {dest, data}.
- tx_vc_credit_gnt, in, VC_W, per-VC credit return pulse from the switch port.
- err_credit_ovf, out, 1, sticky credit-overflow flag.
- sent_count, out, 32, packets injected since reset.
REQ-003 The tx_* ports SHALL map one-to-one onto the vc_target, packet and vc_credit_gnt signals of a noc_if switch rx port.

Function
REQ-004 The block SHALL accept a packet in each cycle where in_valid and in_ready are both high, into a 2-entry in-order FIFO.
REQ-005 in_ready SHALL be high exactly when the FIFO holds fewer than 2 entries, based on registered occupancy. It SHALL NOT depend combinationally on in_valid.
REQ-006 The block SHALL keep one credit counter per VC, each $clog2(VC_FIFO_DEPTH)+1 bits wide.
REQ-007 Each cycle, if the FIFO is non-empty and at least one VC has credit > 0, the block SHALL issue the head packet:
- Pick the first VC with credit, searching round-robin from the VC after the last VC used.
- Drive tx_vc_target one-hot on the next clock edge, registered.
- Drive tx_packet on the same edge.
- Pop the FIFO and decrement that VC's counter.
REQ-008 tx_vc_target SHALL be asserted for exactly one cycle per packet. It SHALL be 0 in any cycle with no issue, and tx_packet then holds its last value.
REQ-009 Latency SHALL be 1 cycle: a packet accepted into an empty FIFO at edge t SHALL appear on tx at edge t+1, provided credit exists.
REQ-010 Issue rate SHALL reach 1 packet per cycle when credits allow. A simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-011 A tx_vc_credit_gnt bit SHALL increment its VC counter at the next edge. A grant and an issue on the same VC in the same cycle SHALL net to no change.
REQ-012 A grant that would push a counter above VC_FIFO_DEPTH-1 SHALL leave the counter at its maximum and set err_credit_ovf, which stays high until reset.
REQ-013 When all credits are 0, the block SHALL stall: no issue, FIFO held, and in_ready low once the FIFO is full.
REQ-014 Packets SHALL leave in acceptance order regardless of VC choice.
REQ-015 sent_count SHALL increment once per issued packet and wrap modulo 2^32.

Reset
REQ-016 While rst is low at a clock edge, the following SHALL hold at the next edge:
- All credit counters = VC_FIFO_DEPTH-1.
- FIFO empty and in_ready = 0.
- tx_vc_target = 0 and tx_packet = 0.
- Round-robin pointer = VC0, so VC0 is searched first.
- err_credit_ovf = 0 and sent_count = 0.
REQ-017 in_ready SHALL rise in the first cycle after rst is sampled high.
REQ-018 Reset asserted mid-operation SHALL discard buffered packets and restore all credits without emitting any further tx_vc_target pulse.

Structure
REQ-019 DEFAULT_D_W, DEFAULT_VC_W and DEFAULT_VC_FIFO_DEPTH SHALL come from common_pkg.
REQ-020 The credit counter width SHALL be a localparam.
REQ-021 The round-robin one-hot picker SHALL be a sub-module, noc_vc_rr_pick (inputs: eligible mask, last grant; output: one-hot grant).

Verification
All scenarios use VC_W=2 and VC_FIFO_DEPTH=4, giving 3 credits per VC.
REQ-022 Single packet dest=1, data=0xA5 accepted after reset -> next cycle tx_vc_target=01, tx_packet={1,0xA5}, sent_count=1.
REQ-023 Push 8 back-to-back packets with no grants -> 6 issued alternating VC 01,10,01,10,01,10; then stall; in_ready low with 2 buffered.
REQ-024 From REQ-023, pulse tx_vc_credit_gnt=10 once -> exactly one packet issued on VC 10, next cycle; order preserved.
REQ-025 Grant on VC0 while VC0 holds 3 credits -> err_credit_ovf=1 and stays 1; credit remains 3.
REQ-026 Grant and issue on the same VC in the same cycle, credit at 1 -> credit remains 1 afterwards.
REQ-027 Assert rst with 2 buffered packets and all credits 0 -> no tx pulse; after release, all credits 3, FIFO empty, in_ready=1.
